// File: rtl/cpu_pkg.sv
// Shared constants for the execute-side arithmetic units.
// Operation encodings and FSM state codes for muldiv_unit.
package cpu_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_MULH = 2'b01;
    localparam logic [1:0] MD_DIVU = 2'b10;
    localparam logic [1:0] MD_REMU = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/muldiv_unit_if.sv
// Start/busy/done bundle between control, register bank and muldiv_unit.
// master = requester side, slave = the arithmetic unit.
interface muldiv_unit_if;
    import cpu_pkg::*;

    logic                  start;
    logic [1:0]            op;
    logic [WORD_WIDTH-1:0] a;
    logic [WORD_WIDTH-1:0] b;
    logic                  busy;
    logic                  done;
    logic [WORD_WIDTH-1:0] result;
    logic                  div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, div_by_zero
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit.
// One iteration per cycle, WIDTH iterations, result latched in DONE.
module muldiv_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  md
);

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   trial;
    logic             is_div;

    // hi holds the product high word or the remainder; lo the low word or quotient
    always_comb begin
        is_div  = op_q[1];
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        r_sh    = {hi_q, lo_q[WIDTH-1]};
        trial   = r_sh - {1'b0, b_q};

        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        res_d   = res_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            ST_RUN: begin
                if (is_div) begin
                    hi_d = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], ~trial[WIDTH]};
                end else begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                res_d   = op_q[0] ? hi_q : lo_q;
                dbz_d   = is_div && (b_q == '0);
                state_d = ST_IDLE;
            end
            default: begin
            end
        endcase

        // A start in DONE still retires the finished result above
        if (md.start && (state_q != ST_RUN)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            op_d    = md.op;
            a_d     = md.a;
            b_d     = md.b;
            hi_d    = '0;
            lo_d    = md.op[1] ? md.a : md.b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MUL;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            res_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
        end
    end

    assign md.busy        = (state_q == ST_RUN);
    assign md.done        = done_q;
    assign md.result      = res_q;
    assign md.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes model results,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
    import cpu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] last_res = '0;
    exp_t sbq[$];

    muldiv_unit_if md ();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .md    (md.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int k);
        exp_t e;
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            MD_MUL:  e.res = p[31:0];
            MD_MULH: e.res = p[63:32];
            MD_DIVU: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: e.res = (b == 0) ? a : a % b;
        endcase
        e.dbz = op[1] && (b == 0);
        e.cyc = k + 33;
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!reset && md.done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", 64'(md.result), 64'(e.res));
                chk("div_by_zero", 64'(md.div_by_zero), 64'(e.dbz));
                chk("latency", 64'(cyc), 64'(e.cyc));
                last_res = e.res;
            end
        end
    end

    task automatic scramble();
        md.op = 2'($urandom);
        md.a  = $urandom;
        md.b  = $urandom;
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        sbq.push_back(model(op, a, b, cyc + 1));
        md.start = 1'b1;
        md.op    = op;
        md.a     = a;
        md.b     = b;
        @(negedge clk);
        md.start = 1'b0;
        scramble();
    endtask

    task automatic to_done_cycle();
        repeat (31) @(negedge clk);
        chk("busy_last_iter", 64'(md.busy), 64'd1);
        @(negedge clk);
        chk("busy_in_done", 64'(md.busy), 64'd0);
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        chk("busy_rise", 64'(md.busy), 64'd1);
        to_done_cycle();
        @(negedge clk);
    endtask

    task automatic rand_ops(output logic [1:0] op, output logic [31:0] a, output logic [31:0] b);
        op = 2'($urandom);
        a  = $urandom;
        case ($urandom_range(0, 3))
            0: b = 0;
            1: b = $urandom_range(1, 15);
            default: b = $urandom;
        endcase
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        reset    = 1'b1;
        md.start = 1'b0;
        md.op    = '0;
        md.a     = '0;
        md.b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(md.busy), 64'd0);
        chk("rst_done", 64'(md.done), 64'd0);
        chk("rst_result", 64'(md.result), 64'd0);
        chk("rst_dbz", 64'(md.div_by_zero), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run(MD_MUL, 32'd7, 32'd6);
        run(MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(MD_DIVU, 32'd100, 32'd7);
        run(MD_REMU, 32'd100, 32'd7);
        run(MD_DIVU, 32'd5, 32'd0);
        run(MD_REMU, 32'd5, 32'd0);

        repeat (4) @(negedge clk);
        chk("result_held", 64'(md.result), 64'(last_res));

        // Starts while busy must be ignored
        issue(MD_MUL, 32'd3, 32'd4);
        for (int i = 0; i < 31; i++) begin
            md.start = (i == 4) || (i == 19);
            if (md.start) scramble();
            @(negedge clk);
        end
        md.start = 1'b0;
        chk("busy_last_iter", 64'(md.busy), 64'd1);
        @(negedge clk);
        chk("busy_in_done", 64'(md.busy), 64'd0);
        issue(MD_DIVU, 32'd9, 32'd2);
        to_done_cycle();
        @(negedge clk);
        chk("b2b_done_clears", 64'(md.busy), 64'd0);

        // Reset mid-run discards partial work
        issue(MD_MUL, 32'd5, 32'd9);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk("midrst_busy", 64'(md.busy), 64'd0);
        chk("midrst_done", 64'(md.done), 64'd0);
        chk("midrst_result", 64'(md.result), 64'd0);
        chk("midrst_dbz", 64'(md.div_by_zero), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        run(MD_MUL, 32'd2, 32'd3);

        // Random pairs, second issued in the DONE cycle of the first
        for (int i = 0; i < 20; i++) begin
            rand_ops(rop, ra, rb);
            issue(rop, ra, rb);
            to_done_cycle();
            rand_ops(rop, ra, rb);
            if (i[0]) begin
                @(negedge clk);
                run(rop, ra, rb);
            end else begin
                issue(rop, ra, rb);
                to_done_cycle();
                @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        chk("final_held", 64'(md.result), 64'(last_res));
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit unsigned multiply/divide unit that sits directly downstream of the register bank. It consumes the two operand words A and B and produces one 32-bit result word, which the write-back path stores into the register array. A start/busy/done handshake lets the control logic stall the CPU while the 32-iteration shift-add or restoring-divide sequence runs.

## Interface
- WIDTH, 32: operand and result width; the iteration count equals WIDTH.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  2  operation: 00 MUL (low word of product), 01 MULH (high word of unsigned product), 10 DIVU (quotient), 11 REMU (remainder).
- a  in  WIDTH  operand A from the register bank; multiplicand or dividend.
- b  in  WIDTH  operand B from the register bank; multiplier or divisor.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when result first becomes valid.
- result  out  WIDTH  selected result word; held until the next accepted start.
- div_by_zero  out  1  registered with done for DIVU/REMU when b==0; held with result.

## Operation
- States:
  - IDLE: after reset.
  - RUN: WIDTH iterations.
  - DONE: one cycle, then back to IDLE.
- Transitions:
  - start in IDLE or DONE: capture a, b and op into internal registers, clear the 6-bit iteration counter, go to RUN.
  - RUN: after the iteration with counter == WIDTH-1, go to DONE.
  - DONE without start: go to IDLE.
- start is ignored while busy. The a, b and op inputs may change freely after capture.
- Multiply:
  - 2*WIDTH-bit accumulator {hi, lo}, with lo preloaded with b.
  - Each iteration: if lo[0] is set, add a to hi with carry-out kept (WIDTH+1 bits); then shift the whole {carry, hi, lo} right by 1.
  - After WIDTH iterations, MUL = lo and MULH = hi.
- Divide (restoring):
  - Remainder register r (WIDTH+1 bits) starts at 0; quotient register q is preloaded with a.
  - Each iteration: shift {r, q} left by 1, then compute trial = r − {0, b}.
    - trial non-negative: r = trial, q[0] = 1.
    - trial negative: q[0] = 0.
  - DIVU = q; REMU = r[WIDTH-1:0].
- Divide by zero: no special path. The algorithm naturally yields q = all ones and r = a. div_by_zero = (b_captured == 0) for op 10/11, and 0 for op 00/01.
- All arithmetic is unsigned modulo 2^WIDTH. No overflow flag.

## Timing
- Reset values: busy=0, done=0, result=0, div_by_zero=0, state IDLE, counter 0.
- start accepted at edge k:
  - busy=1 from k+1 through k+WIDTH (WIDTH cycles).
  - At edge k+WIDTH+1: done=1, result and div_by_zero valid, busy=0.
  - Total latency is WIDTH+1 = 33 cycles.
- done is high for exactly one cycle. result stays stable until the next accepted start, and is not cleared by that start.
- start in the DONE cycle is accepted back-to-back: done=1 and the new capture happen on the same edge, and busy rises on the next cycle.
- Reset asserted mid-RUN: at the next edge, go to IDLE with all outputs at their reset values; the partial result is discarded.
- Reset has priority over start on the same edge.
- Latency is independent of operand values, including b==0.

## Structure
- Shared package cpu_pkg holds:
  - WORD_WIDTH = 32
  - op encodings MD_MUL, MD_MULH, MD_DIVU, MD_REMU
  - state enum IDLE/RUN/DONE
- Single module; no sub-module. The multiply and divide datapaths share the operand registers and the counter.
- Expected size is about 150–200 lines.

## Test plan
- MUL a=7, b=6 → result=0x0000002A, done 33 cycles after start, div_by_zero=0.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF → result=0xFFFFFFFE. MUL with the same operands → 0x00000001.
- DIVU a=100, b=7 → result=14. REMU with the same operands → 2.
- DIVU a=5, b=0 → result=0xFFFFFFFF, div_by_zero=1. REMU a=5, b=0 → result=5, div_by_zero=1.
- Handshake and back-to-back:
  - Pulse start with new operands at cycles 5 and 20 of a running MUL 3×4 → both ignored, result=12.
  - Start DIVU 9/2 in the DONE cycle → done again 33 cycles later with result=4.
- Reset at cycle 10 of a RUN → next cycle busy=0, done=0, result=0, IDLE. A following MUL 2×3 completes normally → 6.
